axi_lite_arbiter: RTL and testbench

- Two-master to one-slave AXI4-lite arbiter in front of the system crossbar's single upstream port.
- Master 0 is the IFU (read-only fetch). Master 1 is the LSU (read or write).
- Exactly one transaction is in flight at a time. The winner's channels are forwarded combinationally; the loser sees all readies/valids low until the transaction completes.

---
 rtl/axi_lite_arbiter_pkg.sv | 22 ++
 rtl/axi_arb_pick.sv | 46 ++++
 rtl/axi_lite_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types and constants for the two-master AXI4-lite arbiter.
// Round-robin arbitration is selected with the ARB_ROUND_ROBIN_EN macro.
package axi_lite_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    GNT_IFU_R = 2'b01,
    GNT_LSU_R = 2'b10,
    GNT_LSU_W = 2'b11
  } arb_state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/axi_arb_pick.sv
// Combinational grant pick for the IFU/LSU arbiter; fixed LSU priority by default,
// alternating on contention when ARB_ROUND_ROBIN_EN is defined.
module axi_arb_pick
  import axi_lite_arbiter_pkg::*;
(
  input  logic       ifu_req,
  input  logic       lsu_r,
  input  logic       lsu_w,
  input  logic       last_gnt,
  output arb_state_e gnt
);

  logic lsu_req;
  assign lsu_req = lsu_r || lsu_w;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    gnt = IDLE;
    // On contention the master that did not win last time goes first.
    if (lsu_req && ifu_req && last_gnt) begin
      gnt = GNT_IFU_R;
    end else if (lsu_w) begin
      gnt = GNT_LSU_W;
    end else if (lsu_r) begin
      gnt = GNT_LSU_R;
    end else if (ifu_req) begin
      gnt = GNT_IFU_R;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt = IDLE;
    if (lsu_w) begin
      gnt = GNT_LSU_W;
    end else if (lsu_req) begin
      gnt = GNT_LSU_R;
    end else if (ifu_req) begin
      gnt = GNT_IFU_R;
    end
  end
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4-lite arbiter, one transaction
// in flight. Optional round-robin contention handling via ARB_ROUND_ROBIN_EN.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  // IFU read
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic [2:0]          ifu_arsize,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  // LSU read
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  // LSU write
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  // Upstream crossbar port
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arsize,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                busy
);

  arb_state_e state_reg;
  arb_state_e state_next;
  arb_state_e pick_gnt;
  logic       lsu_w;
  logic       lsu_r;
  logic       last_gnt;

  // A write needs both AW and W present; it pre-empts a concurrent LSU read.
  assign lsu_w = lsu_awvalid && lsu_wvalid;
  assign lsu_r = lsu_arvalid && !lsu_w;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_reg <= 1'b0;
    end else if (state_reg == IDLE && state_next != IDLE) begin
      last_gnt_reg <= (state_next != GNT_IFU_R);
    end
  end

  assign last_gnt = last_gnt_reg;
`else
  assign last_gnt = 1'b0;
`endif

  axi_arb_pick u_pick (
    .ifu_req  (ifu_arvalid),
    .lsu_r    (lsu_r),
    .lsu_w    (lsu_w),
    .last_gnt (last_gnt),
    .gnt      (pick_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    busy        = 1'b0;
    ifu_arready = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = RESP_OKAY;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = RESP_OKAY;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bresp   = RESP_OKAY;
    lsu_bvalid  = 1'b0;
    m_araddr    = '0;
    m_arsize    = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    m_awaddr    = '0;
    m_awvalid   = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_wvalid    = 1'b0;
    m_bready    = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = pick_gnt;
      end
      GNT_IFU_R: begin
        busy        = 1'b1;
        m_araddr    = ifu_araddr;
        m_arsize    = ifu_arsize;
        m_arvalid   = ifu_arvalid;
        ifu_arready = m_arready;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
        ifu_rvalid  = m_rvalid;
        m_rready    = ifu_rready;
        if (m_rvalid && ifu_rready) begin
          state_next = IDLE;
        end
      end
      GNT_LSU_R: begin
        busy        = 1'b1;
        m_araddr    = lsu_araddr;
        m_arsize    = lsu_arsize;
        m_arvalid   = lsu_arvalid;
        lsu_arready = m_arready;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
        lsu_rvalid  = m_rvalid;
        m_rready    = lsu_rready;
        if (m_rvalid && lsu_rready) begin
          state_next = IDLE;
        end
      end
      GNT_LSU_W: begin
        busy        = 1'b1;
        m_awaddr    = lsu_awaddr;
        m_awvalid   = lsu_awvalid;
        lsu_awready = m_awready;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        m_wvalid    = lsu_wvalid;
        lsu_wready  = m_wready;
        lsu_bresp   = m_bresp;
        lsu_bvalid  = m_bvalid;
        m_bready    = lsu_bready;
        if (m_bvalid && lsu_bready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed table-driven bench for axi_lite_arbiter plus hand-written reset and
// contention sequences; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_axi_lite_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] WDATA = 32'hdead_beef;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ifu_araddr;
  logic [2:0]    ifu_arsize;
  logic          ifu_arvalid, ifu_arready;
  logic [DW-1:0] ifu_rdata;
  logic [1:0]    ifu_rresp;
  logic          ifu_rvalid, ifu_rready;
  logic [AW-1:0] lsu_araddr;
  logic [2:0]    lsu_arsize;
  logic          lsu_arvalid, lsu_arready;
  logic [DW-1:0] lsu_rdata;
  logic [1:0]    lsu_rresp;
  logic          lsu_rvalid, lsu_rready;
  logic [AW-1:0] lsu_awaddr;
  logic          lsu_awvalid, lsu_awready;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wstrb;
  logic          lsu_wvalid, lsu_wready;
  logic [1:0]    lsu_bresp;
  logic          lsu_bvalid, lsu_bready;
  logic [AW-1:0] m_araddr;
  logic [2:0]    m_arsize;
  logic          m_arvalid, m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rvalid, m_rready;
  logic [AW-1:0] m_awaddr;
  logic          m_awvalid, m_awready;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic          m_wvalid, m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid, m_bready;
  logic          busy;

  always #5 clk = ~clk;

  axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
    .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid),
    .lsu_arready(lsu_arready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .lsu_bready(lsu_bready),
    .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .busy(busy)
  );

  // stim: {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, m_arready, m_rvalid, m_aw/wready, m_bvalid}
  // exp:  {busy, m_arvalid, m_awvalid, m_wvalid, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid, lsu_bvalid}
  typedef struct {
    string       name;
    logic [7:0]  stim;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] ifu_addr;
    logic [31:0] aw_addr;
    logic [8:0]  exp;
    logic [31:0] exp_araddr;
    logic [31:0] exp_awaddr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ifu_rdata;
    logic [31:0] exp_lsu_rdata;
    logic [5:0]  exp_resp;  // {ifu_rresp, lsu_rresp, lsu_bresp}
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [8:0] act_flags;
  assign act_flags = {busy, m_arvalid, m_awvalid, m_wvalid, ifu_arready, lsu_arready,
                      ifu_rvalid, lsu_rvalid, lsu_bvalid};

  function automatic vec_t mk(input string n, input logic [7:0] s, input logic [1:0] r,
                              input logic [31:0] rd, input logic [31:0] ia,
                              input logic [31:0] wa, input logic [8:0] e,
                              input logic [31:0] ea, input logic [31:0] ew,
                              input logic [31:0] ed, input logic [31:0] eir,
                              input logic [31:0] elr, input logic [5:0] er);
    vec_t v;
    v.name = n; v.stim = s; v.resp = r; v.rdata = rd; v.ifu_addr = ia; v.aw_addr = wa;
    v.exp = e; v.exp_araddr = ea; v.exp_awaddr = ew; v.exp_wdata = ed;
    v.exp_ifu_rdata = eir; v.exp_lsu_rdata = elr; v.exp_resp = er;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic mwr;
    {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid, m_arready, m_rvalid, mwr, m_bvalid} = v.stim;
    m_awready  = mwr;
    m_wready   = mwr;
    m_rresp    = v.resp;
    m_bresp    = v.resp;
    m_rdata    = v.rdata;
    ifu_araddr = v.ifu_addr;
    lsu_awaddr = v.aw_addr;
  endtask

  task automatic drive_idle();
    {ifu_arvalid, lsu_arvalid, lsu_awvalid, lsu_wvalid} = '0;
    {m_arready, m_rvalid, m_awready, m_wready, m_bvalid} = '0;
    m_rresp = 2'b00; m_bresp = 2'b00; m_rdata = '0;
  endtask

  initial begin
    logic exp_lsu;
    rst = 1'b1;
    ifu_arsize = 3'd2; lsu_arsize = 3'd2;
    ifu_rready = 1'b1; lsu_rready = 1'b1; lsu_bready = 1'b1;
    lsu_araddr = 32'h0f00_0020; lsu_awaddr = '0; ifu_araddr = 32'h3000_0000;
    lsu_wdata = WDATA; lsu_wstrb = 4'hf;
    drive_idle();
    ifu_arvalid = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;

    // IFU alone: bubble, AR, wait, R, IDLE (rvalid still high must not leak)
    vecs.push_back(mk("ifu_bubble",  8'b1000_1000, 2'b00, 32'h0,         32'h3000_0000, 32'h0,         9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("ifu_ar",      8'b1000_1000, 2'b00, 32'h0,         32'h3000_0000, 32'h0,         9'b1_1_0_0_1_0_0_0_0, 32'h3000_0000, 32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("ifu_wait",    8'b0000_1000, 2'b00, 32'h0,         32'h3000_0000, 32'h0,         9'b1_0_0_0_1_0_0_0_0, 32'h3000_0000, 32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("ifu_r",       8'b0000_1100, 2'b00, 32'h0000_0413, 32'h3000_0000, 32'h0,         9'b1_0_0_0_1_0_1_0_0, 32'h3000_0000, 32'h0,         32'h0, 32'h0000_0413, 32'h0,         6'b00_00_00));
    vecs.push_back(mk("ifu_done",    8'b0000_0100, 2'b00, 32'h0000_0413, 32'h3000_0000, 32'h0,         9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    // IFU and LSU write together: write first (DECERR forwarded), one gap, then IFU
    vecs.push_back(mk("mix_idle",    8'b1011_0010, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0010, 9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("mix_w",       8'b1011_0010, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0010, 9'b1_0_1_1_0_0_0_0_0, 32'h0,         32'h0f00_0010, WDATA, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("mix_b",       8'b1000_0011, 2'b11, 32'h0,         32'h3000_0004, 32'h0f00_0010, 9'b1_0_0_0_0_0_0_0_1, 32'h0,         32'h0f00_0010, WDATA, 32'h0,         32'h0,         6'b00_00_11));
    vecs.push_back(mk("mix_gap",     8'b1000_0000, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0010, 9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("mix_ifu_ar",  8'b1000_1000, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0010, 9'b1_1_0_0_1_0_0_0_0, 32'h3000_0004, 32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("mix_ifu_r",   8'b0000_1100, 2'b00, 32'h0000_0001, 32'h3000_0004, 32'h0f00_0010, 9'b1_0_0_0_1_0_1_0_0, 32'h3000_0004, 32'h0,         32'h0, 32'h0000_0001, 32'h0,         6'b00_00_00));
    vecs.push_back(mk("mix_done",    8'b0000_0000, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0010, 9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    // LSU read + write together: write first, then read with AR and R in one cycle (SLVERR)
    vecs.push_back(mk("both_idle",   8'b0111_0010, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0024, 9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("both_w",      8'b0111_1010, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0024, 9'b1_0_1_1_0_0_0_0_0, 32'h0,         32'h0f00_0024, WDATA, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("both_b",      8'b0100_1011, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0024, 9'b1_0_0_0_0_0_0_0_1, 32'h0,         32'h0f00_0024, WDATA, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("both_gap",    8'b0100_1000, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0024, 9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));
    vecs.push_back(mk("both_r_err",  8'b0100_1100, 2'b10, 32'hbad0_0bad, 32'h3000_0004, 32'h0f00_0024, 9'b1_1_0_0_0_1_0_1_0, 32'h0f00_0020, 32'h0,         32'h0, 32'h0,         32'hbad0_0bad, 6'b00_10_00));
    vecs.push_back(mk("both_done",   8'b0000_0000, 2'b00, 32'h0,         32'h3000_0004, 32'h0f00_0024, 9'b0_0_0_0_0_0_0_0_0, 32'h0,         32'h0,         32'h0, 32'h0,         32'h0,         6'b00_00_00));

    // Reset state, with requests and responses present during reset
    repeat (2) @(negedge clk);
    #1;
    chk("reset_flags", {23'd0, act_flags}, 32'h0);
    chk("reset_araddr", m_araddr, 32'h0);
    chk("reset_ifu_rdata", ifu_rdata, 32'h0);
    $display("txn reset: flags=%b", act_flags);
    drive_idle();
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, "_flags"},  {23'd0, act_flags}, {23'd0, vecs[i].exp});
      chk({vecs[i].name, "_araddr"}, m_araddr, vecs[i].exp_araddr);
      chk({vecs[i].name, "_awaddr"}, m_awaddr, vecs[i].exp_awaddr);
      chk({vecs[i].name, "_wdata"},  m_wdata, vecs[i].exp_wdata);
      chk({vecs[i].name, "_ifu_rdata"}, ifu_rdata, vecs[i].exp_ifu_rdata);
      chk({vecs[i].name, "_lsu_rdata"}, lsu_rdata, vecs[i].exp_lsu_rdata);
      chk({vecs[i].name, "_resp"}, {26'd0, ifu_rresp, lsu_rresp, lsu_bresp}, {26'd0, vecs[i].exp_resp});
      $display("txn %0d %s: flags=%b araddr=%08h awaddr=%08h", i, vecs[i].name, act_flags, m_araddr, m_awaddr);
    end

    // rst pulsed mid LSU read abandons it; a following IFU read is granted normally
    @(negedge clk);
    drive_idle();
    lsu_araddr = 32'h0f00_0030;
    lsu_arvalid = 1'b1;
    #1;
    chk("rstmid_idle_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstmid_granted", {30'd0, busy, m_arvalid}, 32'h3);
    chk("rstmid_araddr", m_araddr, 32'h0f00_0030);
    rst = 1'b1;
    m_arready = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_flags", {23'd0, act_flags}, 32'h0);
    chk("rstmid_araddr0", m_araddr, 32'h0);
    $display("txn rst_mid: flags=%b", act_flags);
    rst = 1'b0;
    lsu_arvalid = 1'b0;
    ifu_arvalid = 1'b1;
    ifu_araddr = 32'h3000_0008;
    @(negedge clk);
    #1;
    chk("rstmid_ifu_flags", {23'd0, act_flags}, {23'd0, 9'b1_1_0_0_1_0_0_0_0});
    chk("rstmid_ifu_araddr", m_araddr, 32'h3000_0008);
    ifu_arvalid = 1'b0;
    m_rvalid = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmid_ifu_done", {31'd0, busy}, 32'h0);
    $display("txn rst_recover: busy=%b", busy);

    // Continuous IFU + LSU read requests, each served in one cycle
    rst = 1'b1;
    drive_idle();
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("contend_idle", {31'd0, busy}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_lsu = (k % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      chk($sformatf("contend_%0d_lsu", k), {31'd0, lsu_arready}, {31'd0, exp_lsu});
      chk($sformatf("contend_%0d_ifu", k), {31'd0, ifu_arready}, {31'd0, !exp_lsu});
      $display("txn contend %0d: lsu_arready=%b ifu_arready=%b", k, lsu_arready, ifu_arready);
      @(negedge clk);
      #1;
      chk($sformatf("contend_%0d_gap", k), {31'd0, busy}, 32'h0);
    end

    drive_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
